// File: rtl/jtkiwi_shram_arb.sv
// Access sequencer for the 8 kB work RAM shared by the main and sub Z80s.
// Build macro JTKIWI_SHR_RR_EN selects round-robin tie-break; default is main-wins.
module jtkiwi_shram_arb #(
  parameter int AW = 13,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          main_cs,
  input  logic          main_rnw,
  input  logic [AW-1:0] main_addr,
  input  logic [DW-1:0] main_din,
  output logic [DW-1:0] main_dout,
  output logic          main_wait,
  input  logic          sub_cs,
  input  logic          sub_rnw,
  input  logic [AW-1:0] sub_addr,
  input  logic [DW-1:0] sub_din,
  output logic [DW-1:0] sub_dout,
  output logic          sub_wait,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout,
  output logic [7:0]    st_dout
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_M_ADDR = 3'd1,
    ST_M_DATA = 3'd2,
    ST_S_ADDR = 3'd3,
    ST_S_DATA = 3'd4
  } state_t;

  localparam logic OWN_MAIN = 1'b0;
  localparam logic OWN_SUB  = 1'b1;

  state_t        state_q, state_d;
  logic          served_m_q, served_m_d;
  logic          served_s_q, served_s_d;
  logic          last_owner_q, last_owner_d;
  logic [DW-1:0] main_dout_q, main_dout_d;
  logic [DW-1:0] sub_dout_q, sub_dout_d;
  logic [DW-1:0] ram_din_q, ram_din_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic          ram_we_q, ram_we_d;
  logic          pend_m, pend_s;
  logic          grant_m, grant_s, done_m, done_s;

  assign pend_m    = main_cs & ~served_m_q;
  assign pend_s    = sub_cs & ~served_s_q;
  assign main_wait = pend_m;
  assign sub_wait  = pend_s;
  assign main_dout = main_dout_q;
  assign sub_dout  = sub_dout_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign ram_we    = ram_we_q;
  assign st_dout   = {3'd0, last_owner_q, served_s_q, served_m_q, state_q[1:0]};

  // Next-state: grant, address/data phases and completion bookkeeping
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    main_dout_d  = main_dout_q;
    sub_dout_d   = sub_dout_q;
    ram_addr_d   = ram_addr_q;
    ram_din_d    = ram_din_q;
    ram_we_d     = 1'b0;
    grant_m      = 1'b0;
    grant_s      = 1'b0;
    done_m       = 1'b0;
    done_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend_m && pend_s) begin
`ifdef JTKIWI_SHR_RR_EN
          if (last_owner_q == OWN_SUB) begin
            grant_m = 1'b1;
          end else begin
            grant_s = 1'b1;
          end
`else
          grant_m = 1'b1;
`endif
        end else if (pend_m) begin
          grant_m = 1'b1;
        end else if (pend_s) begin
          grant_s = 1'b1;
        end else begin
          grant_m = 1'b0;
        end
      end
      ST_M_ADDR: begin
        if (main_rnw) begin
          state_d = ST_M_DATA;
        end else begin
          done_m = 1'b1;
        end
      end
      ST_M_DATA: begin
        main_dout_d = ram_dout;
        done_m      = 1'b1;
      end
      ST_S_ADDR: begin
        if (sub_rnw) begin
          state_d = ST_S_DATA;
        end else begin
          done_s = 1'b1;
        end
      end
      ST_S_DATA: begin
        sub_dout_d = ram_dout;
        done_s     = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // A finishing access hands the RAM straight to a waiting peer, no idle bubble
    if (done_m) begin
      last_owner_d = OWN_MAIN;
      if (pend_s) begin
        grant_s = 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (done_s) begin
      last_owner_d = OWN_SUB;
      if (pend_m) begin
        grant_m = 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      last_owner_d = last_owner_q;
    end
    if (grant_m) begin
      state_d    = ST_M_ADDR;
      ram_addr_d = main_addr;
      ram_din_d  = main_din;
      ram_we_d   = ~main_rnw;
    end else if (grant_s) begin
      state_d    = ST_S_ADDR;
      ram_addr_d = sub_addr;
      ram_din_d  = sub_din;
      ram_we_d   = ~sub_rnw;
    end else begin
      ram_we_d = 1'b0;
    end
    served_m_d = main_cs & (served_m_q | done_m);
    served_s_d = sub_cs & (served_s_q | done_s);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      served_m_q   <= 1'b0;
      served_s_q   <= 1'b0;
      last_owner_q <= OWN_SUB;
      main_dout_q  <= {DW{1'b0}};
      sub_dout_q   <= {DW{1'b0}};
      ram_addr_q   <= {AW{1'b0}};
      ram_din_q    <= {DW{1'b0}};
      ram_we_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      served_m_q   <= served_m_d;
      served_s_q   <= served_s_d;
      last_owner_q <= last_owner_d;
      main_dout_q  <= main_dout_d;
      sub_dout_q   <= sub_dout_d;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
      ram_we_q     <= ram_we_d;
    end
  end

endmodule

// File: tb/tb_jtkiwi_shram_arb.sv
// Directed and randomized bench for jtkiwi_shram_arb with a behavioural RAM
// and a shadow-memory scoreboard that applies accesses in completion order.
module tb_jtkiwi_shram_arb;

  logic        clk, rst;
  logic        main_cs, main_rnw, sub_cs, sub_rnw;
  logic [12:0] main_addr, sub_addr, ram_addr;
  logic [7:0]  main_din, sub_din, main_dout, sub_dout, ram_din, ram_dout, st_dout;
  logic        main_wait, sub_wait, ram_we;

  logic        bd_we;
  logic [12:0] bd_addr;
  logic [7:0]  bd_data;
  logic [7:0]  mem [8192];

  int n_checks, n_errors;

  int          phase [2];
  int          cnt   [2];
  int          wcnt  [2];
  logic        rc_cs  [2];
  logic        rc_rnw [2];
  logic [12:0] rc_addr[2];
  logic [7:0]  rc_din [2];
  logic [7:0]  shadow [16];

  jtkiwi_shram_arb #(.AW(13), .DW(8)) dut (
    .clk(clk), .rst(rst),
    .main_cs(main_cs), .main_rnw(main_rnw), .main_addr(main_addr), .main_din(main_din),
    .main_dout(main_dout), .main_wait(main_wait),
    .sub_cs(sub_cs), .sub_rnw(sub_rnw), .sub_addr(sub_addr), .sub_din(sub_din),
    .sub_dout(sub_dout), .sub_wait(sub_wait),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
    .st_dout(st_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM, one-cycle read latency, with a bench backdoor for preloads
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 1 ms");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [12:0] a, input logic [7:0] d);
    tick();
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    tick();
    bd_we = 1'b0;
  endtask

  initial begin
    int w;
    int m_done, s_done;
    n_checks = 0; n_errors = 0;
    rst = 1'b1; bd_we = 1'b0; bd_addr = 13'd0; bd_data = 8'd0;
    main_cs = 1'b0; main_rnw = 1'b1; main_addr = 13'd0; main_din = 8'd0;
    sub_cs = 1'b0; sub_rnw = 1'b1; sub_addr = 13'd0; sub_din = 8'd0;
    repeat (3) tick();
    rst = 1'b0;
    settle();
    chk("rst_main_wait", main_wait, 32'd0);
    chk("rst_sub_wait", sub_wait, 32'd0);
    chk("rst_main_dout", main_dout, 32'd0);
    chk("rst_sub_dout", sub_dout, 32'd0);
    chk("rst_ram_we", ram_we, 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_ram_din", ram_din, 32'd0);
    chk("rst_st", st_dout, 32'h10);

    // Main read, uncontested
    preload(13'h0123, 8'hA5);
    tick(); main_cs = 1'b1; main_rnw = 1'b1; main_addr = 13'h0123; settle();
    chk("t1_wait_c0", main_wait, 32'd1);
    tick(); settle();
    chk("t1_wait_c1", main_wait, 32'd1);
    chk("t1_addr_c1", ram_addr, 32'h123);
    chk("t1_we_c1", ram_we, 32'd0);
    tick(); settle();
    chk("t1_wait_c2", main_wait, 32'd1);
    tick(); settle();
    chk("t1_wait_c3", main_wait, 32'd0);
    chk("t1_dout_c3", main_dout, 32'hA5);
    for (int c = 0; c < 4; c++) begin
      tick(); settle();
      chk("t1_hold_wait", main_wait, 32'd0);
      chk("t1_hold_we", ram_we, 32'd0);
      chk("t1_hold_idle", st_dout[1:0], 32'd0);
    end
    tick(); main_cs = 1'b0; settle();
    chk("t1_dout_hold", main_dout, 32'hA5);

    // Sub write to the top address, then main reads it back
    tick(); sub_cs = 1'b1; sub_rnw = 1'b0; sub_addr = 13'h1FFF; sub_din = 8'h3C; settle();
    chk("t2_wait_c0", sub_wait, 32'd1);
    chk("t2_we_c0", ram_we, 32'd0);
    tick(); settle();
    chk("t2_wait_c1", sub_wait, 32'd1);
    chk("t2_we_c1", ram_we, 32'd1);
    chk("t2_addr_c1", ram_addr, 32'h1FFF);
    chk("t2_din_c1", ram_din, 32'h3C);
    tick(); settle();
    chk("t2_wait_c2", sub_wait, 32'd0);
    chk("t2_we_c2", ram_we, 32'd0);
    tick(); settle();
    chk("t2_we_c3", ram_we, 32'd0);
    tick(); sub_cs = 1'b0; main_cs = 1'b1; main_rnw = 1'b1; main_addr = 13'h1FFF; settle();
    tick(); settle();
    tick(); settle();
    tick(); settle();
    chk("t2_rb_wait", main_wait, 32'd0);
    chk("t2_rb_dout", main_dout, 32'h3C);
    tick(); main_cs = 1'b0; settle();

    // Simultaneous reads after reset
    preload(13'h0010, 8'h11);
    preload(13'h0020, 8'h22);
    tick(); rst = 1'b1;
    tick(); tick(); rst = 1'b0;
    tick(); main_cs = 1'b1; main_rnw = 1'b1; main_addr = 13'h0010;
    sub_cs = 1'b1; sub_rnw = 1'b1; sub_addr = 13'h0020;
    for (int c = 0; c < 6; c++) begin
      settle();
      chk("t3a_main_wait", main_wait, 32'(c < 3));
      chk("t3a_sub_wait", sub_wait, 32'(c < 5));
      if (c == 3) chk("t3a_main_dout", main_dout, 32'h11);
      else if (c == 5) chk("t3a_sub_dout", sub_dout, 32'h22);
      tick();
    end
    main_cs = 1'b0; sub_cs = 1'b0; settle();
    chk("t3_last_sub", st_dout[4], 32'd1);
    tick(); main_cs = 1'b1; main_rnw = 1'b0; main_addr = 13'h0030; main_din = 8'h44; settle();
    tick(); settle(); tick(); settle();
    chk("t3_mw_done", main_wait, 32'd0);
    tick(); main_cs = 1'b0; settle();
    chk("t3_last_main", st_dout[4], 32'd0);
`ifdef JTKIWI_SHR_RR_EN
    m_done = 5; s_done = 3;
`else
    m_done = 3; s_done = 5;
`endif
    tick(); main_cs = 1'b1; main_rnw = 1'b1; main_addr = 13'h0020;
    sub_cs = 1'b1; sub_rnw = 1'b1; sub_addr = 13'h0010;
    for (int c = 0; c < 6; c++) begin
      settle();
      chk("t3b_main_wait", main_wait, 32'(c < m_done));
      chk("t3b_sub_wait", sub_wait, 32'(c < s_done));
      if (c == m_done) chk("t3b_main_dout", main_dout, 32'h22);
      else if (c == s_done) chk("t3b_sub_dout", sub_dout, 32'h11);
      tick();
    end
    main_cs = 1'b0; sub_cs = 1'b0; settle();

    // Back-to-back: main write then sub read with no idle cycle between
    tick(); main_cs = 1'b1; main_rnw = 1'b0; main_addr = 13'h0040; main_din = 8'h5A; settle();
    chk("t4_mwait_c0", main_wait, 32'd1);
    tick(); sub_cs = 1'b1; sub_rnw = 1'b1; sub_addr = 13'h0030; settle();
    chk("t4_we_c1", ram_we, 32'd1);
    chk("t4_addr_c1", ram_addr, 32'h40);
    chk("t4_din_c1", ram_din, 32'h5A);
    chk("t4_swait_c1", sub_wait, 32'd1);
    tick(); settle();
    chk("t4_mwait_c2", main_wait, 32'd0);
    chk("t4_state_c2", st_dout[1:0], 32'd3);
    chk("t4_addr_c2", ram_addr, 32'h30);
    chk("t4_we_c2", ram_we, 32'd0);
    chk("t4_swait_c2", sub_wait, 32'd1);
    tick(); settle();
    chk("t4_swait_c3", sub_wait, 32'd1);
    tick(); settle();
    chk("t4_swait_c4", sub_wait, 32'd0);
    chk("t4_sdout", sub_dout, 32'h44);
    tick(); main_cs = 1'b0; sub_cs = 1'b0; settle();

    // Main holds cs long after completion while sub keeps requesting
    preload(13'h0055, 8'h77);
    tick(); main_cs = 1'b1; main_rnw = 1'b1; main_addr = 13'h0055; settle();
    tick(); settle(); tick(); settle(); tick(); settle();
    chk("t5_main_dout", main_dout, 32'h77);
    for (int k = 0; k < 3; k++) begin
      tick(); sub_cs = 1'b1; sub_rnw = (k != 0); sub_addr = 13'h0060; sub_din = 8'h99; settle();
      w = 0;
      for (int c = 0; c < 10 && sub_wait; c++) begin
        w++;
        chk("t5_main_idle", main_wait, 32'd0);
        tick(); settle();
      end
      chk("t5_sub_lat", w, 32'((k != 0) ? 3 : 2));
      if (k != 0) chk("t5_sub_rd", sub_dout, 32'h99);
      else chk("t5_sub_served", st_dout[3], 32'd1);
      chk("t5_main_served", st_dout[2], 32'd1);
      tick(); sub_cs = 1'b0; settle();
      chk("t5_main_nowait", main_wait, 32'd0);
    end
    tick(); main_cs = 1'b0; settle();

    // Async reset while main is in its data phase
    tick(); main_cs = 1'b1; main_rnw = 1'b1; main_addr = 13'h0010; settle();
    tick(); settle();
    tick(); settle();
    chk("t6_in_data", st_dout[1:0], 32'd2);
    #1; rst = 1'b1; main_cs = 1'b0; #1;
    chk("t6_state", st_dout[2:0], 32'd0);
    chk("t6_mwait", main_wait, 32'd0);
    chk("t6_swait", sub_wait, 32'd0);
    chk("t6_mdout", main_dout, 32'd0);
    chk("t6_sdout", sub_dout, 32'd0);
    chk("t6_we", ram_we, 32'd0);
    tick(); settle(); chk("t6_we_rst1", ram_we, 32'd0);
    tick(); settle(); chk("t6_we_rst2", ram_we, 32'd0);
    tick(); rst = 1'b0; settle();
    chk("t6_we_post", ram_we, 32'd0);
    chk("t6_st_post", st_dout, 32'h10);

    // Randomized traffic against the shadow-memory scoreboard
    for (int j = 0; j < 16; j++) begin
      tick();
      bd_we = 1'b1; bd_addr = 13'h0100 | 13'(j); bd_data = 8'($urandom);
      shadow[j] = bd_data;
    end
    tick(); bd_we = 1'b0;
    for (int i = 0; i < 2; i++) begin
      phase[i] = 0; cnt[i] = i; wcnt[i] = 0;
      rc_cs[i] = 1'b0; rc_rnw[i] = 1'b1; rc_addr[i] = 13'h0100; rc_din[i] = 8'd0;
    end
    for (int cy = 0; cy < 3000; cy++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if (phase[i] == 0) begin
          if (cnt[i] == 0) begin
            rc_cs[i] = 1'b1;
            rc_rnw[i] = 1'($urandom_range(1, 0));
            rc_addr[i] = 13'h0100 | 13'($urandom_range(15, 0));
            rc_din[i] = 8'($urandom);
            phase[i] = 1; wcnt[i] = 0;
          end else cnt[i]--;
        end else if (phase[i] == 2) begin
          if (cnt[i] == 0) begin
            rc_cs[i] = 1'b0; phase[i] = 0; cnt[i] = $urandom_range(3, 0);
          end else cnt[i]--;
        end
      end
      main_cs = rc_cs[0]; main_rnw = rc_rnw[0]; main_addr = rc_addr[0]; main_din = rc_din[0];
      sub_cs = rc_cs[1]; sub_rnw = rc_rnw[1]; sub_addr = rc_addr[1]; sub_din = rc_din[1];
      settle();
      for (int i = 0; i < 2; i++) begin
        logic       ow;
        logic [7:0] od;
        ow = (i == 0) ? main_wait : sub_wait;
        od = (i == 0) ? main_dout : sub_dout;
        if (phase[i] == 1) begin
          if (ow) begin
            wcnt[i]++;
            if (wcnt[i] > 8) begin
              chk("rnd_timeout", wcnt[i], 32'd5);
              phase[i] = 2; cnt[i] = 0;
            end
          end else begin
            chk("rnd_lat_min", 32'(wcnt[i] >= (rc_rnw[i] ? 3 : 2)), 32'd1);
            chk("rnd_lat_max", 32'(wcnt[i] <= 5), 32'd1);
            if (rc_rnw[i]) chk("rnd_rdata", od, 32'(shadow[rc_addr[i][3:0]]));
            else shadow[rc_addr[i][3:0]] = rc_din[i];
            phase[i] = 2; cnt[i] = $urandom_range(3, 0);
          end
        end else begin
          chk("rnd_no_wait", ow, 32'd0);
        end
      end
    end
    tick(); main_cs = 1'b0; sub_cs = 1'b0; settle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/jtkiwi_shram_arb.md
Name: jtkiwi_shram_arb

Overview:
Arbitrates a single-port shared work RAM (8 kB at main CPU E000-FFFF, sub CPU window) between the main Z80 and the sub/sound Z80.
- Replaces the first-come-first-served latch scheme with an explicit access sequencer.
- Generates per-CPU wait signals for the Z80 wait/devwait inputs, and holds read data so it stays stable for the whole bus cycle.
- Sits between the two CPU wrappers and one jtframe single-port RAM with 1-cycle read latency.

Parameters:
AW, 13, RAM address width
DW, 8, data width

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- main_cs  in  1  main CPU RAM select (mreq & rfsh qualified, level, held for whole bus cycle)
- main_rnw  in  1  main read=1 / write=0
- main_addr  in  AW  main address
- main_din  in  DW  main write data
- main_dout  out  DW  registered read data to main
- main_wait  out  1  main stall request
- sub_cs, sub_rnw, sub_addr, sub_din, sub_dout, sub_wait: same as main, for the sub CPU
- ram_addr  out  AW  RAM address
- ram_din  out  DW  RAM write data
- ram_we  out  1  RAM write strobe
- ram_dout  in  DW  RAM read data, valid one clk after ram_addr
- st_dout  out  8  debug: {3'd0, last_owner, served_s, served_m, state[1:0]}

Behaviour:
- Clocking: all state updates on posedge clk, no cen; arbitration runs at full clk rate.
- FSM states: IDLE, M_ADDR, M_DATA, S_ADDR, S_DATA.
- Pending requests:
  - pend_m = main_cs & ~served_m
  - pend_s = sub_cs & ~served_s
- IDLE:
  - pend_m only -> M_ADDR.
  - pend_s only -> S_ADDR.
  - Both pending -> tie-break (see Optional Feature).
- M_ADDR:
  - ram_addr = main_addr.
  - Write (main_rnw=0): ram_we=1 for exactly this cycle, ram_din = main_din, access completes.
  - Read: go to M_DATA.
- M_DATA: capture ram_dout into main_dout; access completes.
- S_ADDR / S_DATA: identical, using the sub_* signals.
- Completion:
  - Set served_x for the owner if its cs is still high.
  - Record last_owner.
  - Next state: the other requester's *_ADDR if it is pending, else IDLE. No idle bubble on back-to-back accesses.
- served_x is cleared whenever x_cs=0. A CPU holding cs through its remaining T-states is never re-granted; a new access needs cs to drop first.
- Wait outputs are combinational: x_wait = x_cs & ~served_x. Wait asserts in the same cycle cs rises.
- Uncontested latency, main_cs rising in cycle 0:
  - Read: wait is high in cycles 0-2 and low from cycle 3. main_dout is valid from cycle 3.
  - Write: wait is high in cycles 0-1 and ram_we is high in cycle 1. Wait is low from cycle 2.
- Contested access: the loser's wait is extended by the winner's access length (1 or 2 cycles) and proceeds immediately afterwards.
- Abort: if cs drops in *_ADDR of a read, *_DATA still executes and dout updates, but served is not set. A write in *_ADDR is never cancelled.
- ram_we is never asserted outside *_ADDR and never for two consecutive cycles of the same grant.
- Idle outputs: ram_addr holds its last value and ram_we=0.
- x_dout holds its value until the next read completes for that CPU.
- Reset values: state=IDLE; served_m=served_s=0; last_owner=sub, so main wins the first tie; main_dout=sub_dout=0; ram_we=0; ram_addr=0; ram_din=0.
- Reset mid-access: state returns to IDLE immediately (async). No write strobe is emitted during rst or in the first cycle after it.

Optional Feature:
JTKIWI_SHR_RR_EN
- Defined: ties in IDLE go to the requester that is not last_owner (round-robin).
- Undefined: main always wins ties; last_owner is still tracked for st_dout only.

Test Plan:
- Main read only: preload RAM[0x0123]=0xA5, main_cs=1, rnw=1, addr=0x123 at cycle 0 -> main_wait high cycles 0-2, main_dout=0xA5 from cycle 3, no further RAM access while cs is held.
- Sub write only: sub addr=0x1FFF, din=0x3C -> ram_we high exactly one cycle (cycle 1) with ram_addr=0x1FFF; a subsequent main read of 0x1FFF returns 0x3C.
- Simultaneous reads after reset: both cs rise in the same cycle -> main served first (dout at cycle 3), sub at cycle 5. With JTKIWI_SHR_RR_EN, a second simultaneous pair serves sub first.
- Back-to-back: main write overlapped by a sub read pending -> S_ADDR follows M_ADDR directly with no IDLE cycle; sub_wait drops 3 cycles after main's ram_we.
- Held cs: main_cs held 10 cycles after completion while sub repeatedly requests -> main never re-granted, and sub is granted each time its cs rises.
- Async reset asserted in M_DATA -> state IDLE, both waits 0 while cs low, douts 0, ram_we 0 through reset release.
